// File: rtl/wb_pull_fifo.sv
// Byte FIFO filled by Wishbone classic reads issued upstream and drained by
// answering Wishbone classic reads from a downstream controller.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no upstream cycle; start a fetch next edge if not full
// ST_FETCH   | upstream read in flight; cyc/stb held until up_ack_i
module wb_pull_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  up_cyc_o,
  output logic                  up_stb_o,
  output logic                  up_we_o,
  input  logic [DATA_WIDTH-1:0] up_dat_i,
  input  logic                  up_ack_i,
  input  logic                  dn_cyc_i,
  input  logic                  dn_stb_i,
  input  logic                  dn_we_i,
  output logic [DATA_WIDTH-1:0] dn_dat_o,
  output logic                  dn_ack_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } up_state_t;

  up_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] dn_dat_q;
  logic                  dn_ack_q;
  logic                  ack_rd_q;

  logic push, pop;
  logic dn_req, dn_rd_go, dn_wr_go;

  // Upstream fetch FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (count_q < DEPTH_C) state_d = ST_FETCH;
      ST_FETCH: if (up_ack_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign up_cyc_o = (state_q == ST_FETCH);
  assign up_stb_o = (state_q == ST_FETCH);
  assign up_we_o  = 1'b0;

  assign push = (state_q == ST_FETCH) && up_ack_i;

  // Downstream device side; the !dn_ack_o term keeps acks one cycle apart.
  assign dn_req   = dn_cyc_i && dn_stb_i && !dn_ack_q;
  assign dn_rd_go = dn_req && !dn_we_i && !empty_o;
  assign dn_wr_go = dn_req && dn_we_i;
  assign pop      = dn_ack_q && ack_rd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dn_ack_q <= 1'b0;
      ack_rd_q <= 1'b0;
      dn_dat_q <= '0;
    end else begin
      dn_ack_q <= dn_rd_go || dn_wr_go;
      ack_rd_q <= dn_rd_go;
      if (dn_rd_go) dn_dat_q <= mem[rd_ptr_q];
    end
  end

  assign dn_dat_o = dn_dat_q;
  assign dn_ack_o = dn_ack_q;

  // Pointers wrap naturally at DEPTH since they are ADDR_WIDTH bits wide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= up_dat_i;
  end

  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_wb_pull_fifo.sv
// Scoreboard bench for wb_pull_fifo: upstream responder queues each word it
// acks, a downstream monitor pops and compares on every read ack.
module tb_wb_pull_fifo;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       up_cyc_o, up_stb_o, up_we_o;
  logic [7:0] up_dat_i;
  logic       up_ack_i;
  logic       dn_cyc_i, dn_stb_i, dn_we_i;
  logic [7:0] dn_dat_o;
  logic       dn_ack_o;
  logic [4:0] count_o;
  logic       full_o, empty_o;

  wb_pull_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .up_cyc_o(up_cyc_o), .up_stb_o(up_stb_o), .up_we_o(up_we_o),
    .up_dat_i(up_dat_i), .up_ack_i(up_ack_i),
    .dn_cyc_i(dn_cyc_i), .dn_stb_i(dn_stb_i), .dn_we_i(dn_we_i),
    .dn_dat_o(dn_dat_o), .dn_ack_o(dn_ack_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc_num = 0;
  always @(posedge clk_i) cyc_num <= cyc_num + 1;

  logic [7:0] exp_q[$];
  int  up_left = 0;
  int  up_wait = 0;
  logic [7:0] up_next = 8'h00;
  int  last_push_edge = 0;
  int  rx_cnt = 0;
  bit  flow_mon = 0;
  int  max_cnt = 0;
  bit  saw_both = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Upstream responder: acks after up_wait wait states while budget remains.
  initial begin
    int wcnt;
    wcnt = 0;
    up_ack_i = 1'b0;
    up_dat_i = 8'h00;
    forever begin
      @(posedge clk_i);
      #1;
      up_ack_i = 1'b0;
      if (!(up_cyc_o && up_stb_o)) begin
        wcnt = 0;
      end else if (up_left > 0 && rst_ni) begin
        if (wcnt >= up_wait) begin
          up_ack_i = 1'b1;
          up_dat_i = up_next;
          exp_q.push_back(up_next);
          up_next = up_next + 8'h01;
          up_left--;
          wcnt = 0;
          last_push_edge = cyc_num + 1;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Downstream monitor: compares every read ack against the scoreboard.
  initial begin
    bit both_pend;
    logic [4:0] cnt_prev;
    both_pend = 0;
    cnt_prev = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (both_pend && count_o == cnt_prev) saw_both = 1;
      both_pend = 0;
      if (flow_mon) begin
        if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
        if (dn_ack_o && !dn_we_i && up_cyc_o && up_ack_i) begin
          both_pend = 1;
          cnt_prev = count_o;
        end
      end
      if (rst_ni && dn_ack_o && !dn_we_i) begin
        check("dn_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("dn_data", dn_dat_o, exp_q.pop_front());
        rx_cnt++;
      end
    end
  end

  // One downstream access, driven just after an edge; lat = edges to ack or -1.
  task automatic dn_access(input logic we, output int lat);
    dn_cyc_i = 1'b1; dn_stb_i = 1'b1; dn_we_i = we;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk_i);
      #1;
      if (dn_ack_o) begin
        lat = i;
        break;
      end
    end
    #2;
    dn_cyc_i = 1'b0; dn_stb_i = 1'b0; dn_we_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_count(input logic [4:0] target, input int bound);
    for (int i = 0; i < bound && count_o != target; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int lat, n, ack_edge;
    bit any;
    rst_ni = 1'b0;
    dn_cyc_i = 1'b0; dn_stb_i = 1'b0; dn_we_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cyc", up_cyc_o, 0);
    check("rst_we", up_we_o, 0);
    check("rst_ack", dn_ack_o, 0);
    check("rst_dat", dn_dat_o, 0);
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    #2 rst_ni = 1'b1;

    // Fill to full with 0x10.. and confirm no further fetches
    up_next = 8'h10; up_wait = 0; up_left = 1000;
    wait_count(5'd16, 100);
    check("fill_count", count_o, 16);
    check("fill_full", full_o, 1);
    any = 0;
    repeat (20) begin
      @(posedge clk_i);
      #1;
      any |= up_cyc_o;
    end
    check("full_no_fetch", any, 0);

    // One read from full: 1-cycle latency, refetch right after the pop
    dn_cyc_i = 1'b1; dn_stb_i = 1'b1; dn_we_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("full_rd_ack", dn_ack_o, 1);
    #2;
    dn_cyc_i = 1'b0; dn_stb_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("pop_count", count_o, 15);
    check("pop_cyc_low", up_cyc_o, 0);
    @(posedge clk_i);
    #1;
    check("refetch_cyc", up_cyc_o, 1);
    wait_count(5'd16, 20);
    check("refill_count", count_o, 16);

    // Drain everything with no upstream supply
    up_left = 0;
    for (int i = 0; i < 16; i++) dn_access(1'b0, lat);
    check("drain_empty", empty_o, 1);

    // Read on empty is stretched until 0xA5 arrives after 3 wait states
    dn_cyc_i = 1'b1; dn_stb_i = 1'b1; dn_we_i = 1'b0;
    any = 0;
    repeat (5) begin
      @(posedge clk_i);
      #1;
      any |= dn_ack_o;
    end
    check("empty_no_ack", any, 0);
    up_next = 8'hA5; up_wait = 3; up_left = 1;
    ack_edge = -100;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i);
      #1;
      if (dn_ack_o) begin
        ack_edge = cyc_num;
        break;
      end
    end
    check("stretch_ack_delay", ack_edge - last_push_edge, 1);
    #2;
    dn_cyc_i = 1'b0; dn_stb_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("stretch_count", count_o, 0);

    // Continuous flow of 40 words across two pointer wraps
    up_next = 8'h00; up_wait = 0; up_left = 40;
    n = rx_cnt + 40;
    flow_mon = 1; max_cnt = 0; saw_both = 0;
    dn_cyc_i = 1'b1; dn_stb_i = 1'b1; dn_we_i = 1'b0;
    for (int i = 0; i < 400 && rx_cnt < n; i++) begin
      @(posedge clk_i);
      #3;
    end
    dn_cyc_i = 1'b0; dn_stb_i = 1'b0;
    flow_mon = 0;
    check("flow_rx", rx_cnt, n);
    check("flow_max_le16", max_cnt <= 16, 1);
    check("flow_push_pop", saw_both, 1);
    @(posedge clk_i);
    #1;

    // Downstream write with count 3: acked, discarded, head preserved
    up_next = 8'h50; up_wait = 0; up_left = 3;
    wait_count(5'd3, 50);
    check("w_pre_count", count_o, 3);
    dn_access(1'b1, lat);
    check("w_lat", lat, 1);
    check("w_dat_hold", dn_dat_o, 8'h27);
    check("w_count", count_o, 3);
    dn_access(1'b0, lat);
    check("r_lat", lat, 1);
    check("r_count", count_o, 2);

    // Asynchronous reset mid-fetch with count 5
    up_next = 8'h60; up_left = 3;
    wait_count(5'd5, 50);
    for (int i = 0; i < 5 && !up_cyc_o; i++) begin
      @(posedge clk_i);
      #1;
    end
    check("pre_rst_cyc", up_cyc_o, 1);
    check("pre_rst_count", count_o, 5);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_cyc", up_cyc_o, 0);
    check("arst_stb", up_stb_o, 0);
    check("arst_count", count_o, 0);
    check("arst_empty", empty_o, 1);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk_i);
      #1;
      if (up_cyc_o) begin
        n = i;
        break;
      end
    end
    check("post_rst_fetch", n >= 1 && n <= 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
